bubble_sort_ctrl: RTL

Sequencing controller that runs an in-place ascending bubble sort over the team's 2**AW × DW single-write/single-read register memory. It owns the memory's write port (enable, address, data) and read port (address, data) while busy, and walks compare/swap passes until the array is ordered. It sits between the top-level start/done control and the memory instance; the memory is not shared with any other agent during a sort.

---
 rtl/bubble_pkg.sv | 19 +
 rtl/bubble_cmp.sv | 17 +
 rtl/bubble_sort_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bubble_pkg.sv
// Shared types and default sizes for the bubble sort controller.
// Contents: state enum (IDLE..DONE) and the default address/data widths.
package bubble_pkg;

  localparam int unsigned BUBBLE_AW = 5;
  localparam int unsigned BUBBLE_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_LO,
    WR_HI,
    NEXT,
    DONE
  } bubble_state_e;

endpackage

// File: rtl/bubble_cmp.sv
// Combinational greater-than (a > b), signed or unsigned by parameter.
// Ports: a, b (DW) operands; gt_c high when a is strictly greater than b.
module bubble_cmp #(
  parameter int unsigned DW     = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gt_c
);

  always_comb begin
    if (SIGNED) gt_c = ($signed(a) > $signed(b));
    else        gt_c = (a > b);
  end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort sequencer over a 2**AW x DW register memory.
// Ports: clk, reset (sync, active-high); start/len launch a sort; busy, done,
// swap_count report status; mem_we/mem_waddr/mem_wdata drive the write port;
// mem_raddr/mem_rdata use the read port (data one cycle after address).
// Build option: define BUBBLE_EARLY_EXIT_EN to stop after a swap-free pass.
module bubble_sort_ctrl
  import bubble_pkg::*;
#(
  parameter int unsigned AW     = BUBBLE_AW,
  parameter int unsigned DW     = BUBBLE_DW,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [15:0]   swap_count,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] DEPTH = LW'(1) << AW;

  bubble_state_e state, state_n;
  logic [AW-1:0] j, j_n, lim, lim_n;
  logic [DW-1:0] a_reg, a_n, b_reg, b_n;
  logic [15:0]   cnt_n;
  logic          busy_n, done_n, we_n;
  logic [AW-1:0] waddr_n, raddr_n;
  logic [DW-1:0] wdata_n;
  logic [AW:0]   eff_len_c, j_inc_c;
  logic          gt_c;
`ifdef BUBBLE_EARLY_EXIT_EN
  logic          swapped, swapped_n;
`endif

  // Lengths beyond the memory depth clamp to the full array.
  assign eff_len_c = (len > DEPTH) ? DEPTH : len;
  assign j_inc_c   = {1'b0, j} + LW'(1);

  // a_reg holds element j; the read data in CMP is element j+1.
  bubble_cmp #(.DW(DW), .SIGNED(SIGNED)) u_cmp (
    .a    (a_reg),
    .b    (mem_rdata),
    .gt_c (gt_c)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      j          <= '0;
      lim        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      swap_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      mem_raddr  <= '0;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      j          <= j_n;
      lim        <= lim_n;
      a_reg      <= a_n;
      b_reg      <= b_n;
      swap_count <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      mem_we     <= we_n;
      mem_waddr  <= waddr_n;
      mem_wdata  <= wdata_n;
      mem_raddr  <= raddr_n;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped    <= swapped_n;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    state_n = state;
    j_n     = j;
    lim_n   = lim;
    a_n     = a_reg;
    b_n     = b_reg;
    cnt_n   = swap_count;
`ifdef BUBBLE_EARLY_EXIT_EN
    swapped_n = swapped;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (eff_len_c >= LW'(2)) begin
            lim_n   = AW'(eff_len_c - LW'(1));
            j_n     = '0;
            cnt_n   = '0;
`ifdef BUBBLE_EARLY_EXIT_EN
            swapped_n = 1'b0;
`endif
            state_n = RD_A;
          end else begin
            state_n = DONE;
          end
        end
      end
      RD_A: state_n = RD_B;
      RD_B: begin
        a_n     = mem_rdata;
        state_n = CMP;
      end
      CMP: begin
        b_n     = mem_rdata;
        state_n = gt_c ? WR_LO : NEXT;
      end
      WR_LO: state_n = WR_HI;
      WR_HI: begin
`ifdef BUBBLE_EARLY_EXIT_EN
        swapped_n = 1'b1;
`endif
        if (swap_count != 16'hFFFF) cnt_n = swap_count + 16'd1;
        state_n = NEXT;
      end
      NEXT: begin
        if (j_inc_c < {1'b0, lim}) begin
          j_n     = AW'(j_inc_c);
          state_n = RD_A;
        end else if (lim == AW'(1)) begin
          state_n = DONE;
`ifdef BUBBLE_EARLY_EXIT_EN
        end else if (!swapped) begin
          state_n = DONE;
`endif
        end else begin
          lim_n   = lim - AW'(1);
          j_n     = '0;
`ifdef BUBBLE_EARLY_EXIT_EN
          swapped_n = 1'b0;
`endif
          state_n = RD_A;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    we_n    = (state_n == WR_LO) || (state_n == WR_HI);
    waddr_n = mem_waddr;
    wdata_n = mem_wdata;
    raddr_n = mem_raddr;
    if (state_n == RD_A) raddr_n = j_n;
    if (state_n == RD_B) raddr_n = AW'({1'b0, j_n} + LW'(1));
    if (state_n == WR_LO) begin
      waddr_n = j_n;
      wdata_n = b_n;
    end
    if (state_n == WR_HI) begin
      waddr_n = AW'({1'b0, j_n} + LW'(1));
      wdata_n = a_reg;
    end
  end

endmodule
